// File: rtl/arm_pipe_pkg.sv
// ---------------------------------------------------------------------------
// arm_pipe_pkg
//   Shared constants and types for the ARM pipeline hazard scoreboard.
//   - LAT_ALU / LAT_LOAD : canonical result latencies of the two common
//                          instruction classes.
//   - REG_PC             : register index that holds the PC. It never creates
//                          a data hazard.
//   - DEF_REG_AW/DEF_LAT_W : default register-index and counter widths.
//   - sb_entry_t         : one scoreboard entry at the default widths.
// ---------------------------------------------------------------------------
package arm_pipe_pkg;

  localparam int LAT_ALU    = 1;
  localparam int LAT_LOAD   = 2;
  localparam int REG_PC     = 15;

  localparam int DEF_REG_AW = 4;
  localparam int DEF_LAT_W  = 3;

  typedef struct packed {
    logic                 pend;
    logic [DEF_LAT_W-1:0] rdy_cnt;
    logic [DEF_LAT_W:0]   wb_cnt;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_entry.sv
// ---------------------------------------------------------------------------
// scoreboard_entry
//   Countdown state for one architectural register.
//   Ports:
//     clk, rst      clock / asynchronous active-low reset
//     freeze        pipeline frozen by data-memory wait; counters hold
//     load          a new write to this register is accepted this cycle
//     load_lat      result latency of that write (already forced >= 1)
//     kill          the in-flight write to this register is wrong-path
//     pend          a write to this register is in flight
//     rdy_cnt       cycles until the result reaches the bypass network
//     wb_cnt        cycles until the result is written to the register file
//     pend_nxt      value pend takes on the next edge (for the popcount)
// ---------------------------------------------------------------------------
module scoreboard_entry
  import arm_pipe_pkg::*;
#(
  parameter int LAT_W  = DEF_LAT_W,
  parameter int WB_GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             load,
  input  logic [LAT_W-1:0] load_lat,
  input  logic             kill,
  output logic             pend,
  output logic [LAT_W-1:0] rdy_cnt,
  output logic [LAT_W:0]   wb_cnt,
  output logic             pend_nxt
);

  localparam logic [LAT_W-1:0] RDY_ONE = LAT_W'(1);
  localparam logic [LAT_W:0]   WB_ONE  = (LAT_W+1)'(1);
  localparam logic [LAT_W:0]   GAP_W   = (LAT_W+1)'(WB_GAP);

  logic [LAT_W-1:0] rdy_nxt;
  logic [LAT_W:0]   wb_nxt;

  // Kill and load never coincide (a flush blocks acceptance), so their
  // order only documents intent. A load wins over the countdown so that a
  // re-issue on the retiring edge keeps the register pending.
  always_comb begin
    pend_nxt = pend;
    rdy_nxt  = rdy_cnt;
    wb_nxt   = wb_cnt;
    if (kill) begin
      pend_nxt = 1'b0;
      rdy_nxt  = '0;
      wb_nxt   = '0;
    end else if (load) begin
      pend_nxt = 1'b1;
      rdy_nxt  = load_lat;
      wb_nxt   = {1'b0, load_lat} + GAP_W;
    end else if (pend && !freeze) begin
      if (rdy_cnt != '0) begin
        rdy_nxt = rdy_cnt - RDY_ONE;
      end
      if (wb_cnt <= WB_ONE) begin
        pend_nxt = 1'b0;
        rdy_nxt  = '0;
        wb_nxt   = '0;
      end else begin
        wb_nxt = wb_cnt - WB_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= 1'b0;
      rdy_cnt <= '0;
      wb_cnt  <= '0;
    end else begin
      pend    <= pend_nxt;
      rdy_cnt <= rdy_nxt;
      wb_cnt  <= wb_nxt;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Latency-aware hazard unit beside the ID stage. Tracks in-flight register
//   writes with one countdown entry per architectural register and decides
//   whether the ID instruction must stall or can be accepted.
//   Ports:
//     clk, rst        clock / asynchronous active-low reset
//     forward         bypass network enabled
//     issue_*         ID-stage instruction: valid, sources, destination,
//                     result latency (0 is treated as 1)
//     mem_wait        data memory busy; whole pipeline frozen
//     flush           taken branch; kills the instruction in ID and the one
//                     issued on the previous cycle
//     stall           hold PC/IF/ID this cycle (combinational)
//     issue_ack       ID instruction accepted this cycle
//     pending_cnt     registered count of pending registers
//   Optional (macro STALL_STATS_EN):
//     stall_cycles    saturating count of stalled cycles
//     raw_stalls      saturating count of cycles with a source hazard
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int LAT_W    = DEF_LAT_W,
  parameter int WB_GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_src1,
  input  logic [REG_AW-1:0] issue_src2,
  input  logic              issue_two_src,
  input  logic              issue_wb_en,
  input  logic [REG_AW-1:0] issue_dest,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              mem_wait,
  input  logic              flush,
  output logic              stall,
  output logic              issue_ack,
  output logic [REG_AW:0]   pending_cnt
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       raw_stalls
`endif
);

  localparam int             TBL   = 1 << REG_AW;
  localparam logic [LAT_W:0] GAP_W = (LAT_W+1)'(WB_GAP);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [LAT_W-1:0]    rdy_cnt [NUM_REGS];
  logic [LAT_W:0]      wb_cnt  [NUM_REGS];

  logic [TBL-1:0]      haz_tbl;
  logic [TBL-1:0]      waw_tbl;

  logic [LAT_W-1:0]    lat_eff;
  logic [LAT_W:0]      wb_need;
  logic                src1_haz;
  logic                src2_haz;
  logic                waw_haz;

  logic                last_valid;
  logic [REG_AW-1:0]   last_dest;

  assign lat_eff = (issue_lat == '0) ? LAT_W'(LAT_ALU) : issue_lat;
  assign wb_need = {1'b0, lat_eff} + GAP_W;

  // Per-register hazard tables, padded to the full index range so that
  // indices with no tracked register read as hazard-free. With forwarding,
  // a ready count of 1 means the result reaches the bypass in time for the
  // consumer, so only counts above 1 stall.
  for (genvar g = 0; g < TBL; g++) begin : g_reg
    if (g < NUM_REGS) begin : g_live
      scoreboard_entry #(
        .LAT_W  (LAT_W),
        .WB_GAP (WB_GAP)
      ) u_entry (
        .clk      (clk),
        .rst      (rst),
        .freeze   (mem_wait),
        .load     (issue_ack && issue_wb_en && (issue_dest == REG_AW'(g))),
        .load_lat (lat_eff),
        .kill     (flush && last_valid && (last_dest == REG_AW'(g))),
        .pend     (pend[g]),
        .rdy_cnt  (rdy_cnt[g]),
        .wb_cnt   (wb_cnt[g]),
        .pend_nxt (pend_nxt[g])
      );
      if (g == REG_PC) begin : g_pc
        assign haz_tbl[g] = 1'b0;
      end else begin : g_gpr
        assign haz_tbl[g] = pend[g] && (!forward || (rdy_cnt[g] > LAT_W'(1)));
      end
      assign waw_tbl[g] = pend[g] && (wb_need <= wb_cnt[g]);
    end else begin : g_none
      assign haz_tbl[g] = 1'b0;
      assign waw_tbl[g] = 1'b0;
    end
  end

  // Stall and accept decisions are same-cycle so IF/ID can be held at once.
  always_comb begin
    src1_haz  = haz_tbl[issue_src1];
    src2_haz  = issue_two_src && haz_tbl[issue_src2];
    waw_haz   = issue_wb_en && waw_tbl[issue_dest];
    stall     = issue_valid && (src1_haz || src2_haz || waw_haz || mem_wait);
    issue_ack = issue_valid && !stall && !flush;
  end

  // The last-issue record only needs to remember writes: an accepted
  // instruction without a destination has no entry for a flush to kill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_valid <= 1'b0;
      last_dest  <= '0;
    end else if (flush) begin
      last_valid <= 1'b0;
    end else if (!mem_wait) begin
      last_valid <= issue_ack && issue_wb_en;
      if (issue_ack) begin
        last_dest <= issue_dest;
      end
    end
  end

  function automatic logic [REG_AW:0] count_ones(input logic [NUM_REGS-1:0] v);
    logic [REG_AW:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n = n + (REG_AW+1)'(v[i]);
    end
    return n;
  endfunction

  // Counting the next-state vector keeps pending_cnt in step with pend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_cnt <= '0;
    end else begin
      pending_cnt <= count_ones(pend_nxt);
    end
  end

`ifdef STALL_STATS_EN
  logic raw_haz;

  assign raw_haz = issue_valid && (src1_haz || src2_haz);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      raw_stalls   <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (raw_haz && (raw_stalls != '1)) begin
        raw_stalls <= raw_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard with a behavioural reference model.
//   Each step drives one ID-stage cycle, the model predicts stall/ack and the
//   pending count after the edge, and the prediction is queued until the
//   DUT outputs are sampled. Honours STALL_STATS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
  import arm_pipe_pkg::*;

  localparam int NR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward;
  logic       issue_valid;
  logic [3:0] issue_src1;
  logic [3:0] issue_src2;
  logic       issue_two_src;
  logic       issue_wb_en;
  logic [3:0] issue_dest;
  logic [2:0] issue_lat;
  logic       mem_wait;
  logic       flush;
  logic       stall;
  logic       issue_ack;
  logic [4:0] pending_cnt;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] raw_stalls;
  logic [31:0] mdl_stall_cycles;
  logic [31:0] mdl_raw_stalls;
`endif

  int checks = 0;
  int errors = 0;

  sb_entry_t  mdl [NR];
  logic       mdl_last_v;
  logic [3:0] mdl_last_d;

  typedef struct {
    string       tag;
    logic        stall;
    logic        ack;
    logic [4:0]  pcnt;
    logic [31:0] scyc;
    logic [31:0] raw;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .forward       (forward),
    .issue_valid   (issue_valid),
    .issue_src1    (issue_src1),
    .issue_src2    (issue_src2),
    .issue_two_src (issue_two_src),
    .issue_wb_en   (issue_wb_en),
    .issue_dest    (issue_dest),
    .issue_lat     (issue_lat),
    .mem_wait      (mem_wait),
    .flush         (flush),
    .stall         (stall),
    .issue_ack     (issue_ack),
    .pending_cnt   (pending_cnt)
`ifdef STALL_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .raw_stalls    (raw_stalls)
`endif
  );

  task automatic resetModel();
    for (int r = 0; r < NR; r++) begin
      mdl[r] = '0;
    end
    mdl_last_v = 1'b0;
    mdl_last_d = '0;
`ifdef STALL_STATS_EN
    mdl_stall_cycles = '0;
    mdl_raw_stalls   = '0;
`endif
  endtask

  // Source is blocked while its producer is pending; with the bypass on it
  // is blocked only until the producer is one cycle from forwardable.
  function automatic logic mdlSrcHaz(input logic [3:0] r);
    if (r == 4'(REG_PC)) return 1'b0;
    if (!mdl[r].pend) return 1'b0;
    if (!forward) return 1'b1;
    return (mdl[r].rdy_cnt >= 3'd2);
  endfunction

  function automatic logic [4:0] mdlCount();
    logic [4:0] n;
    n = '0;
    for (int r = 0; r < NR; r++) begin
      if (mdl[r].pend) n = n + 5'd1;
    end
    return n;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pops the oldest prediction and compares it with the DUT: stall/ack
  // mid-cycle, registered outputs just after the following rising edge.
  task automatic checkOutput();
    exp_t e;
    #1;
    e = exp_q.pop_front();
    checkValue({e.tag, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
    checkValue({e.tag, ".ack"}, {31'd0, issue_ack}, {31'd0, e.ack});
    @(posedge clk);
    #1;
    checkValue({e.tag, ".pending_cnt"}, {27'd0, pending_cnt}, {27'd0, e.pcnt});
`ifdef STALL_STATS_EN
    checkValue({e.tag, ".stall_cycles"}, stall_cycles, e.scyc);
    checkValue({e.tag, ".raw_stalls"}, raw_stalls, e.raw);
`endif
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [3:0] s1,
                               input logic [3:0] s2, input logic two, input logic wb,
                               input logic [3:0] d, input logic [2:0] lat,
                               input logic mw, input logic fl);
    exp_t       e;
    logic       src_h;
    logic       waw_h;
    logic [2:0] le;
    @(negedge clk);
    issue_valid   = v;
    issue_src1    = s1;
    issue_src2    = s2;
    issue_two_src = two;
    issue_wb_en   = wb;
    issue_dest    = d;
    issue_lat     = lat;
    mem_wait      = mw;
    flush         = fl;

    le      = (lat == 3'd0) ? 3'd1 : lat;
    src_h   = v && (mdlSrcHaz(s1) || (two && mdlSrcHaz(s2)));
    waw_h   = wb && mdl[d].pend && (({1'b0, le} + 4'd1) <= mdl[d].wb_cnt);
    e.tag   = tag;
    e.stall = v && (src_h || waw_h || mw);
    e.ack   = v && !e.stall && !fl;

`ifdef STALL_STATS_EN
    if (e.stall && mdl_stall_cycles != 32'hFFFF_FFFF) mdl_stall_cycles = mdl_stall_cycles + 32'd1;
    if (src_h && mdl_raw_stalls != 32'hFFFF_FFFF) mdl_raw_stalls = mdl_raw_stalls + 32'd1;
    e.scyc = mdl_stall_cycles;
    e.raw  = mdl_raw_stalls;
`else
    e.scyc = '0;
    e.raw  = '0;
`endif

    if (!mw) begin
      for (int r = 0; r < NR; r++) begin
        if (mdl[r].pend) begin
          if (mdl[r].rdy_cnt != 3'd0) mdl[r].rdy_cnt = mdl[r].rdy_cnt - 3'd1;
          if (mdl[r].wb_cnt == 4'd1) mdl[r] = '0;
          else mdl[r].wb_cnt = mdl[r].wb_cnt - 4'd1;
        end
      end
    end
    if (fl && mdl_last_v) mdl[mdl_last_d] = '0;
    if (e.ack && wb) begin
      mdl[d].pend    = 1'b1;
      mdl[d].rdy_cnt = le;
      mdl[d].wb_cnt  = {1'b0, le} + 4'd1;
    end
    if (fl) begin
      mdl_last_v = 1'b0;
    end else if (!mw) begin
      mdl_last_v = e.ack && wb;
      mdl_last_d = d;
    end
    e.pcnt = mdlCount();
    exp_q.push_back(e);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus("idle", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 3'd1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b0;
    forward       = 1'b1;
    issue_valid   = 1'b0;
    issue_src1    = '0;
    issue_src2    = '0;
    issue_two_src = 1'b0;
    issue_wb_en   = 1'b0;
    issue_dest    = '0;
    issue_lat     = '0;
    mem_wait      = 1'b0;
    flush         = 1'b0;
    resetModel();

    repeat (2) @(negedge clk);
    checkValue("reset.stall", {31'd0, stall}, 32'd0);
    checkValue("reset.ack", {31'd0, issue_ack}, 32'd0);
    checkValue("reset.pending_cnt", {27'd0, pending_cnt}, 32'd0);
    rst = 1'b1;

    $display("[TB] ALU to ALU dependency");
    applyStimulus("alu_prod", 1, 4'd0, 4'd0, 0, 1, 4'd2, 3'd1, 0, 0);
    applyStimulus("alu_cons", 1, 4'd2, 4'd0, 0, 1, 4'd7, 3'd1, 0, 0);
    idle(3);
    forward = 1'b0;
    applyStimulus("nofwd_prod", 1, 4'd0, 4'd0, 0, 1, 4'd2, 3'd1, 0, 0);
    repeat (3) applyStimulus("nofwd_cons", 1, 4'd2, 4'd0, 0, 0, 4'd0, 3'd1, 0, 0);
    idle(3);
    forward = 1'b1;

    $display("[TB] load-use");
    applyStimulus("load", 1, 4'd0, 4'd0, 0, 1, 4'd3, 3'd2, 0, 0);
    repeat (2) applyStimulus("load_use", 1, 4'd1, 4'd3, 1, 0, 4'd0, 3'd1, 0, 0);
    idle(3);
    applyStimulus("load_b", 1, 4'd0, 4'd0, 0, 1, 4'd3, 3'd2, 0, 0);
    applyStimulus("one_src", 1, 4'd1, 4'd3, 0, 0, 4'd0, 3'd1, 0, 0);
    idle(3);

    $display("[TB] memory wait");
    applyStimulus("r4_prod", 1, 4'd0, 4'd0, 0, 1, 4'd4, 3'd2, 0, 0);
    repeat (3) applyStimulus("mw_hold", 1, 4'd4, 4'd0, 0, 0, 4'd0, 3'd1, 1, 0);
    repeat (2) applyStimulus("mw_release", 1, 4'd4, 4'd0, 0, 0, 4'd0, 3'd1, 0, 0);
    idle(4);

    $display("[TB] flush");
    applyStimulus("r5_prod", 1, 4'd0, 4'd0, 0, 1, 4'd5, 3'd2, 0, 0);
    applyStimulus("flush", 1, 4'd5, 4'd0, 0, 0, 4'd0, 3'd1, 0, 1);
    applyStimulus("after_flush", 1, 4'd5, 4'd0, 0, 0, 4'd0, 3'd1, 0, 0);
    idle(3);

    $display("[TB] same-edge retire and re-issue");
    applyStimulus("r6_old", 1, 4'd0, 4'd0, 0, 1, 4'd6, 3'd1, 0, 0);
    idle(1);
    applyStimulus("r6_new", 1, 4'd0, 4'd0, 0, 1, 4'd6, 3'd3, 0, 0);
    repeat (3) applyStimulus("r6_use", 1, 4'd6, 4'd0, 0, 0, 4'd0, 3'd1, 0, 0);
    idle(4);

    $display("[TB] write after write");
    applyStimulus("waw_a", 1, 4'd0, 4'd0, 0, 1, 4'd8, 3'd3, 0, 0);
    repeat (4) applyStimulus("waw_b", 1, 4'd0, 4'd0, 0, 1, 4'd8, 3'd1, 0, 0);
    idle(4);

    $display("[TB] zero latency and PC source");
    applyStimulus("lat0", 1, 4'd0, 4'd0, 0, 1, 4'd9, 3'd0, 0, 0);
    applyStimulus("lat0_use", 1, 4'd9, 4'd0, 0, 0, 4'd0, 3'd1, 0, 0);
    idle(3);
    forward = 1'b0;
    applyStimulus("pc_w", 1, 4'd0, 4'd0, 0, 1, 4'd15, 3'd2, 0, 0);
    applyStimulus("pc_use", 1, 4'd15, 4'd15, 1, 0, 4'd0, 3'd1, 0, 0);
    forward = 1'b1;
    idle(4);

    $display("[TB] flush during memory wait");
    applyStimulus("r10_prod", 1, 4'd0, 4'd0, 0, 1, 4'd10, 3'd3, 0, 0);
    applyStimulus("flush_mw", 1, 4'd0, 4'd0, 0, 0, 4'd0, 3'd1, 1, 1);
    idle(2);

    $display("[TB] reset with registers pending");
    for (int r = 1; r <= 5; r++) begin
      applyStimulus("fill", 1, 4'd0, 4'd0, 0, 1, 4'(r), 3'd7, 0, 0);
    end
    @(negedge clk);
    issue_valid   = 1'b1;
    issue_src1    = 4'd1;
    issue_two_src = 1'b0;
    issue_wb_en   = 1'b0;
    mem_wait      = 1'b0;
    flush         = 1'b0;
    #1;
    checkValue("pre_reset.stall", {31'd0, stall}, {31'd0, mdlSrcHaz(4'd1)});
    checkValue("pre_reset.pending_cnt", {27'd0, pending_cnt}, {27'd0, mdlCount()});
    #1;
    rst = 1'b0;
    #1;
    resetModel();
    checkValue("async_reset.stall", {31'd0, stall}, 32'd0);
    checkValue("async_reset.pending_cnt", {27'd0, pending_cnt}, 32'd0);
`ifdef STALL_STATS_EN
    checkValue("async_reset.stall_cycles", stall_cycles, 32'd0);
`endif
    @(negedge clk);
    issue_valid = 1'b0;
    rst         = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
